// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
// Provides the 4-bit operation type and the sixteen opcode constants used
// by alu_core and alu_muldiv.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD   = 4'b0000;
    localparam alu_op_t ALU_SUB   = 4'b0001;
    localparam alu_op_t ALU_MUL   = 4'b0010;
    localparam alu_op_t ALU_DIV   = 4'b0011;
    localparam alu_op_t ALU_AND   = 4'b0100;
    localparam alu_op_t ALU_OR    = 4'b0101;
    localparam alu_op_t ALU_XOR   = 4'b0110;
    localparam alu_op_t ALU_NOR   = 4'b0111;
    localparam alu_op_t ALU_SLT   = 4'b1000;
    localparam alu_op_t ALU_SLTU  = 4'b1001;
    localparam alu_op_t ALU_SLL   = 4'b1010;
    localparam alu_op_t ALU_SRL   = 4'b1011;
    localparam alu_op_t ALU_SRA   = 4'b1100;
    localparam alu_op_t ALU_MULU  = 4'b1101;
    localparam alu_op_t ALU_DIVU  = 4'b1110;
    localparam alu_op_t ALU_PASSB = 4'b1111;

endpackage

// File: rtl/alu_muldiv.sv
// Combinational multiply/divide unit of the execute-stage ALU.
// Ports:
//   a, b  : WIDTH-bit operands
//   op    : operation code; only MUL, MULU, DIV and DIVU produce non-zero output
//   lo    : low product word or quotient
//   hi    : high product word or remainder
//   exc   : divide-by-zero or signed-divide overflow
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             exc
);

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic                      b_zero;
    logic                      div_ovf;
    logic signed [WIDTH-1:0]   a_s;
    logic signed [WIDTH-1:0]   bs_safe;
    logic        [WIDTH-1:0]   bu_safe;
    logic signed [WIDTH-1:0]   quot_s;
    logic signed [WIDTH-1:0]   rem_s;
    logic        [WIDTH-1:0]   quot_u;
    logic        [WIDTH-1:0]   rem_u;

    // Operands are widened before multiplying so the full double-width product is kept.
    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign b_zero  = (b == '0);
    assign div_ovf = (a == MOST_NEG) && (b == '1);

    // The divider never sees the faulting divisors; those results are forced below.
    assign a_s     = $signed(a);
    assign bs_safe = (b_zero || div_ovf) ? $signed(ONE) : $signed(b);
    assign bu_safe = b_zero ? ONE : b;

    assign quot_s = a_s / bs_safe;
    assign rem_s  = a_s % bs_safe;
    assign quot_u = a / bu_safe;
    assign rem_u  = a % bu_safe;

    always_comb begin
        lo  = '0;
        hi  = '0;
        exc = 1'b0;
        case (alu_op_t'(op))
            ALU_MUL: begin
                lo = prod_s[WIDTH-1:0];
                hi = prod_s[2*WIDTH-1:WIDTH];
            end
            ALU_MULU: begin
                lo = prod_u[WIDTH-1:0];
                hi = prod_u[2*WIDTH-1:WIDTH];
            end
            ALU_DIV: begin
                if (b_zero) begin
                    lo  = '1;
                    hi  = a;
                    exc = 1'b1;
                end else if (div_ovf) begin
                    lo  = a;
                    hi  = '0;
                    exc = 1'b1;
                end else begin
                    lo = quot_s;
                    hi = rem_s;
                end
            end
            ALU_DIVU: begin
                if (b_zero) begin
                    lo  = '1;
                    hi  = a;
                    exc = 1'b1;
                end else begin
                    lo = quot_u;
                    hi = rem_u;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// Registered integer ALU for the datapath execute stage.
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   A, B          : WIDTH-bit operands
//   ctl           : 4-bit operation select
//   R             : primary result (registered)
//   S             : secondary result: high product word / remainder (registered)
//   alu_exception : fault flag of the operation currently on R/S (registered)
// Every output reflects the operands and code presented one clock earlier.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ctl,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] S,
    output logic             alu_exception
);

    logic [WIDTH-1:0]        md_lo;
    logic [WIDTH-1:0]        md_hi;
    logic                    md_exc;
    logic [WIDTH-1:0]        sum;
    logic [WIDTH-1:0]        diff;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [SHW-1:0]          shamt;

    logic [WIDTH-1:0]        r_d, r_q;
    logic [WIDTH-1:0]        s_d, s_q;
    logic                    exc_d, exc_q;

    alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .a   (A),
        .b   (B),
        .op  (ctl),
        .lo  (md_lo),
        .hi  (md_hi),
        .exc (md_exc)
    );

    assign sum   = A + B;
    assign diff  = A - B;
    assign a_s   = $signed(A);
    assign b_s   = $signed(B);
    assign shamt = B[SHW-1:0];

    always_comb begin
        r_d   = '0;
        s_d   = '0;
        exc_d = 1'b0;
        case (alu_op_t'(ctl))
            ALU_ADD: begin
                r_d   = sum;
                // Overflow: like-signed operands giving a result of the other sign.
                exc_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_SUB: begin
                r_d   = diff;
                exc_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_MUL, ALU_MULU, ALU_DIV, ALU_DIVU: begin
                r_d   = md_lo;
                s_d   = md_hi;
                exc_d = md_exc;
            end
            ALU_AND:   r_d = A & B;
            ALU_OR:    r_d = A | B;
            ALU_XOR:   r_d = A ^ B;
            ALU_NOR:   r_d = ~(A | B);
            ALU_SLT:   r_d = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU:  r_d = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_SLL:   r_d = A << shamt;
            ALU_SRL:   r_d = A >> shamt;
            ALU_SRA:   r_d = a_s >>> shamt;
            ALU_PASSB: r_d = B;
            default: ;
        endcase
    end

    // ---- output register stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            s_q   <= '0;
            exc_q <= 1'b0;
        end else begin
            r_q   <= r_d;
            s_q   <= s_d;
            exc_q <= exc_d;
        end
    end

    assign R             = r_q;
    assign S             = s_q;
    assign alu_exception = exc_q;

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, B;
    logic [3:0]  ctl;
    logic [31:0] R, S;
    logic        alu_exception;

    int errs   = 0;
    int checks = 0;

    alu_core #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .A             (A),
        .B             (B),
        .ctl           (ctl),
        .R             (R),
        .S             (S),
        .alu_exception (alu_exception)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: evaluate each operation with 64-bit integer arithmetic on the
    // mathematical values of the operands, then reduce to 32 bits.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                  output logic [31:0] r, output logic [31:0] s, output logic e);
        longint          sa, sb, t, q, m;
        longint unsigned ua, ub, u;
        longint          max_s, min_s;
        int              sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        max_s = (64'sd1 <<< 31) - 64'sd1;
        min_s = -(64'sd1 <<< 31);
        sh = int'(b % 32);
        r = 32'd0; s = 32'd0; e = 1'b0;
        case (op)
            4'd0: begin t = sa + sb; r = t[31:0]; e = (t > max_s) || (t < min_s); end
            4'd1: begin t = sa - sb; r = t[31:0]; e = (t > max_s) || (t < min_s); end
            4'd2: begin t = sa * sb; r = t[31:0]; s = t[63:32]; end
            4'd3: begin
                if (b == 32'd0) begin r = 32'hFFFF_FFFF; s = a; e = 1'b1; end
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    if (q > max_s) begin r = a; s = 32'd0; e = 1'b1; end
                    else begin r = q[31:0]; s = m[31:0]; end
                end
            end
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: r = ~(a | b);
            4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd9: r = (ua < ub) ? 32'd1 : 32'd0;
            4'd10: begin u = ua << sh; r = u[31:0]; end
            4'd11: begin u = ua >> sh; r = u[31:0]; end
            4'd12: begin t = sa >>> sh; r = t[31:0]; end
            4'd13: begin u = ua * ub; r = u[31:0]; s = u[63:32]; end
            4'd14: begin
                if (b == 32'd0) begin r = 32'hFFFF_FFFF; s = a; e = 1'b1; end
                else begin u = ua / ub; r = u[31:0]; u = ua % ub; s = u[31:0]; end
            end
            default: r = b;
        endcase
    endfunction

    // Present one operation, clock it, and compare against given constants.
    task automatic run_exp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                           input logic [31:0] er, input logic [31:0] es, input logic ee,
                           input string tag);
        A = a; B = b; ctl = op;
        @(posedge clk); #1;
        chk({tag, "_R"}, R, er);
        chk({tag, "_S"}, S, es);
        chk({tag, "_exc"}, {31'd0, alu_exception}, {31'd0, ee});
    endtask

    // Present one operation, clock it, and compare against the reference model.
    task automatic run_mdl(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                           input string tag);
        logic [31:0] er, es;
        logic        ee;
        model(a, b, op, er, es, ee);
        run_exp(a, b, op, er, es, ee, tag);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [6];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        // Reset dominates a multiply whose result would be non-zero.
        rst = 1'b1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; ctl = ALU_MUL;
        @(posedge clk); #1;
        chk("rst_R", R, 32'h0);
        chk("rst_S", S, 32'h0);
        chk("rst_exc", {31'd0, alu_exception}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_R", R, 32'h1);
        chk("post_rst_S", S, 32'h0);

        run_exp(32'h0000_0001, 32'h0000_0001, ALU_ADD, 32'h0000_0002, 32'h0, 1'b0, "add1");
        run_exp(32'h8000_0001, 32'hFFFF_FFFF, ALU_ADD, 32'h8000_0000, 32'h0, 1'b0, "add2");
        run_exp(32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD, 32'h8000_0000, 32'h0, 1'b1, "add_ovf");
        run_exp(32'h8000_0001, 32'hFFFF_FFFF, ALU_SUB, 32'h8000_0002, 32'h0, 1'b0, "sub1");
        run_exp(32'h8000_0000, 32'h0000_0001, ALU_SUB, 32'h7FFF_FFFF, 32'h0, 1'b1, "sub_ovf");
        run_exp(32'h8000_0001, 32'hFFFF_FFFF, ALU_MUL, 32'h7FFF_FFFF, 32'h0, 1'b0, "mul");
        run_exp(32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_MULU, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, "mulu");
        run_exp(32'h8000_0001, 32'hFFFF_FFFF, ALU_DIV, 32'h7FFF_FFFF, 32'h0, 1'b0, "div1");
        run_exp(32'hFFFF_FFF9, 32'h0000_0002, ALU_DIV, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "div_neg");
        run_exp(32'h0000_0005, 32'h0000_0000, ALU_DIV, 32'hFFFF_FFFF, 32'h5, 1'b1, "div_zero");
        run_exp(32'h8000_0000, 32'hFFFF_FFFF, ALU_DIV, 32'h8000_0000, 32'h0, 1'b1, "div_ovf");
        run_exp(32'h0000_0007, 32'h0000_0000, ALU_DIVU, 32'hFFFF_FFFF, 32'h7, 1'b1, "divu_zero");
        run_exp(32'h8000_0000, 32'd31, ALU_SRA, 32'hFFFF_FFFF, 32'h0, 1'b0, "sra31");
        run_exp(32'h8000_0000, 32'd31, ALU_SRL, 32'h0000_0001, 32'h0, 1'b0, "srl31");
        run_exp(32'h0000_0001, 32'd33, ALU_SLL, 32'h0000_0002, 32'h0, 1'b0, "sll_wrap");
        run_exp(32'hFFFF_FFFF, 32'h0000_0001, ALU_SLT, 32'h1, 32'h0, 1'b0, "slt");
        run_exp(32'hFFFF_FFFF, 32'h0000_0001, ALU_SLTU, 32'h0, 32'h0, 1'b0, "sltu");
        run_exp(32'h1234_5678, 32'hCAFE_F00D, ALU_PASSB, 32'hCAFE_F00D, 32'h0, 1'b0, "passb");

        // Back-to-back opcodes on fixed operands; the ADD overflow must not linger.
        run_exp(32'h7FFF_FFFF, 32'h1, ALU_ADD, 32'h8000_0000, 32'h0, 1'b1, "b2b_add");
        run_exp(32'h7FFF_FFFF, 32'h1, ALU_SUB, 32'h7FFF_FFFE, 32'h0, 1'b0, "b2b_sub");
        run_exp(32'h7FFF_FFFF, 32'h1, ALU_MUL, 32'h7FFF_FFFF, 32'h0, 1'b0, "b2b_mul");
        run_exp(32'h7FFF_FFFF, 32'h1, ALU_DIV, 32'h7FFF_FFFF, 32'h0, 1'b0, "b2b_div");

        // Inputs changing between edges must not disturb the registered outputs.
        A = 32'hDEAD_BEEF; B = 32'h0; ctl = ALU_DIV;
        #3;
        chk("hold_R", R, 32'h7FFF_FFFF);
        chk("hold_exc", {31'd0, alu_exception}, 32'd0);

        // Reset beats a faulting divide in the same cycle.
        run_exp(32'h5, 32'h0, ALU_DIV, 32'hFFFF_FFFF, 32'h5, 1'b1, "pre_rst_div");
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst2_R", R, 32'h0);
        chk("rst2_S", S, 32'h0);
        chk("rst2_exc", {31'd0, alu_exception}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            run_mdl(pick(), pick(), op, $sformatf("rnd%0d_op%0d", i, op));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
